// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an optional FWFT read port.
module fifo_flags #(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 8,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              clr_err,
    output logic [DWIDTH-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AE_LEVEL);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wptr_q, wptr_d;
    logic [AWIDTH-1:0] rptr_q, rptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              rd_acc, wr_acc;

    // Flags come straight from the registered occupancy.
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Acceptance and next-state; a full FIFO still takes a write
    // when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc  = rd_en && !empty;
        wr_acc  = wr_en && (!full || rd_acc);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) wptr_d = wptr_q + 1'b1;
        if (rd_acc) rptr_d = rptr_q + 1'b1;
        if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
        if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
        // Set wins over clear.
        ovf_d = (ovf_q && !clr_err) || (wr_en && !wr_acc);
        udf_d = (udf_q && !clr_err) || (rd_en && !rd_acc);
    end

    // Pointer, count and error-flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) mem_q[wptr_q] <= data_in;
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented combinationally while data is held.
        always_comb begin
            data_out = empty ? '0 : mem_q[rptr_q];
        end
    end else begin : g_std
        logic [DWIDTH-1:0] dout_q;

        // Registered read port that holds between reads.
        always_ff @(posedge clk) begin
            if (!rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem_q[rptr_q];
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_flags.sv
// Self-checking bench for fifo_flags: queue model and read scoreboard,
// a vector table for the error-flag corner cases, and an FWFT instance.
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en, clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty;
    logic [5:0] count;
    logic       overflow, underflow;

    logic       f_wr, f_rd, f_clr;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [5:0] f_count;

    int nchecks = 0;
    int nerrors = 0;

    logic [7:0] mq [$];
    logic [7:0] sbq [$];
    logic       m_ovf, m_udf;

    typedef struct {
        logic       w;
        logic       r;
        logic       c;
        logic [7:0] d;
        int         cnt;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    fifo_flags dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .clr_err(clr_err), .data_out(data_out),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_flags #(.FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(f_wr), .rd_en(f_rd),
        .data_in(f_din), .clr_err(f_clr), .data_out(f_dout),
        .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_flags();
        int n;
        n = mq.size();
        chk("count", 32'(count), n);
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == 32));
        chk("almost_full", 32'(almost_full), 32'(n >= 28));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 4));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
    endtask

    // One clock of stimulus on the standard instance, with model update.
    task automatic step(input logic w, input logic r, input logic c,
                        input logic [7:0] d);
        logic racc, wacc;
        logic [7:0] e;
        wr_en = w; rd_en = r; clr_err = c; data_in = d;
        racc = r && (mq.size() != 0);
        wacc = w && ((mq.size() != 32) || racc);
        if (racc) sbq.push_back(mq.pop_front());
        if (wacc) mq.push_back(d);
        m_ovf = (m_ovf && !c) || (w && !wacc);
        m_udf = (m_udf && !c) || (r && !racc);
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0; clr_err = 0;
        if (racc) begin
            e = sbq.pop_front();
            chk("rdata", 32'(data_out), 32'(e));
        end
        check_flags();
    endtask

    task automatic fstep(input logic w, input logic r, input logic [7:0] d);
        f_wr = w; f_rd = r; f_din = d;
        @(posedge clk); #1;
        f_wr = 0; f_rd = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] held;
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h5C, 1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0};

        rst = 0; wr_en = 1; rd_en = 0; clr_err = 0; data_in = 8'h99;
        f_wr = 0; f_rd = 0; f_clr = 0; f_din = 0;
        m_ovf = 0; m_udf = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1; wr_en = 0;
        check_flags();
        chk("reset_dout", 32'(data_out), 0);

        // Fill 0x00..0x1F.
        for (int i = 0; i < 32; i++) step(1, 0, 0, 8'(i));
        // Rejected write into a full FIFO.
        step(1, 0, 0, 8'hAA);
        // Drain in order.
        for (int i = 0; i < 32; i++) step(0, 1, 0, 8'h00);
        held = data_out;
        step(0, 0, 0, 8'h00);
        chk("dout_hold", 32'(data_out), 32'(held));
        step(0, 0, 1, 8'h00);

        // Full: overflow set-wins over clear, then simultaneous rd/wr.
        for (int i = 0; i < 32; i++) step(1, 0, 0, 8'(i));
        step(1, 0, 1, 8'hEE);
        step(0, 0, 1, 8'h00);
        step(1, 1, 0, 8'h77);
        for (int i = 0; i < 32; i++) step(0, 1, 0, 8'h00);

        // Underflow corner cases from a vector table.
        foreach (tbl[i]) begin
            step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
            chk("tbl_count", 32'(count), tbl[i].cnt);
            chk("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
            chk("tbl_underflow", 32'(underflow), 32'(tbl[i].udf));
        end

        // Interleaved traffic across a pointer wrap.
        pat = 8'h40;
        for (int i = 0; i < 100; i++) begin
            logic w, r;
            w = (mq.size() < 3) && (i % 3 != 2);
            r = (i % 2 == 1) && (mq.size() > 0);
            step(w, r, 0, pat);
            if (w) pat++;
            if (count > 6'd3) chk("wrap_count_le3", 32'(count), 3);
        end
        while (mq.size() > 0) step(0, 1, 0, 8'h00);

        // FWFT instance.
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        fstep(1, 0, 8'h11);
        chk("fwft_first", 32'(f_dout), 32'h11);
        fstep(1, 0, 8'h22);
        chk("fwft_hold", 32'(f_dout), 32'h11);
        chk("fwft_count2", 32'(f_count), 2);
        fstep(0, 1, 8'h00);
        chk("fwft_next", 32'(f_dout), 32'h22);
        fstep(0, 1, 8'h00);
        chk("fwft_empty", 32'(f_empty), 1);
        chk("fwft_dout0", 32'(f_dout), 0);
        chk("fwft_udf", 32'(f_udf), 0);
        for (int i = 0; i < 3; i++) fstep(1, 0, 8'(8'h30 + i));
        chk("fwft_count3", 32'(f_count), 3);
        chk("fwft_head", 32'(f_dout), 32'h30);
        rst = 0;
        f_wr = 1; f_din = 8'hFF;
        @(posedge clk); #1;
        rst = 1; f_wr = 0;
        chk("fwft_rst_count", 32'(f_count), 0);
        chk("fwft_rst_empty", 32'(f_empty), 1);
        chk("fwft_rst_dout", 32'(f_dout), 0);
        chk("std_rst_dout", 32'(data_out), 0);
        chk("std_rst_count", 32'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule
